fifo_wr_arbiter: RTL and testbench

Round-robin burst arbiter that shares the single write port of the team's synchronous FIFO (FIFO_WIDTH x FIFO_DEPTH) between NUM_REQ producers.
- Grants one producer at a time for up to MAX_BURST words.
- Gates every write with the FIFO full flag so that FIFO overflow never occurs.
- Monitors the FIFO's wr_ack/overflow outputs and raises sticky error flags on protocol violations.
- Sits directly in front of the FIFO write side; the read side is untouched.

---
 rtl/fifo_wr_arbiter_pkg.sv | 20 ++
 rtl/fifo_wr_arbiter_if.sv | 41 ++++
 rtl/fifo_wr_arbiter_rr_picker.sv | 31 +++
 rtl/fifo_wr_arbiter.sv | 140 ++++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 437 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_wr_arbiter_pkg.sv
// fifo_wr_arbiter shared types: FSM state enum, default sizes,
// and the index-width helper used by the interface and the logic.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  localparam int NUM_REQ_DEF   = 4;
  localparam int MAX_BURST_DEF = 4;
  localparam int DATA_W_DEF    = 16;

  // $clog2 with a floor of one bit so a 2-way
  // (or degenerate) index still has a real width
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Producer + FIFO write-side bundle of fifo_wr_arbiter.
// master: arbiter side; slave: producers/FIFO side.
interface fifo_wr_arbiter_if #(
  parameter int NUM_REQ = fifo_arb_pkg::NUM_REQ_DEF,
  parameter int DATA_W  = fifo_arb_pkg::DATA_W_DEF
);
  localparam int IW = fifo_arb_pkg::idx_w(NUM_REQ);

  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        gnt;
  logic [NUM_REQ-1:0]        acc;
  logic                      fifo_wr_en;
  logic [DATA_W-1:0]         fifo_data_in;
  logic                      fifo_full;
  logic                      fifo_wr_ack;
  logic                      fifo_overflow;
  logic [IW-1:0]             owner;
  logic                      busy;
  logic                      err_overflow;
  logic                      err_ack;

  modport master (
    input  req, req_data,
    input  fifo_full, fifo_wr_ack,
    input  fifo_overflow,
    output gnt, acc, fifo_wr_en,
    output fifo_data_in, owner, busy,
    output err_overflow, err_ack
  );

  modport slave (
    output req, req_data,
    output fifo_full, fifo_wr_ack,
    output fifo_overflow,
    input  gnt, acc, fifo_wr_en,
    input  fifo_data_in, owner, busy,
    input  err_overflow, err_ack
  );

endinterface

// File: rtl/fifo_wr_arbiter_rr_picker.sv
// Round-robin picker: first set i_req bit above i_ptr (wrapping).
// Ports: i_req, i_ptr in; o_oh one-hot, o_idx index, o_vld out.
module rr_picker #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_oh,
  output logic [IW-1:0] o_idx,
  output logic          o_vld
);

  always_comb begin
    int j;
    j     = 0;
    o_oh  = '0;
    o_idx = '0;
    o_vld = 1'b0;
    for (int k = 1; k <= N; k++) begin
      j = int'(i_ptr) + k;
      if (j >= N) j = j - N;
      if (!o_vld && i_req[j[IW-1:0]]) begin
        o_vld            = 1'b1;
        o_oh[j[IW-1:0]]  = 1'b1;
        o_idx            = j[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port.
// Ports: clk, rst_n (async low), bus (fifo_wr_arbiter_if.master).
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ   = NUM_REQ_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int MAX_BURST = MAX_BURST_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  fifo_wr_arbiter_if.master   bus
);

  localparam int IW = idx_w(NUM_REQ);
  localparam int CW = $clog2(MAX_BURST) + 1;
  localparam logic [CW-1:0] LAST =
    CW'(MAX_BURST - 1);

  arb_state_e         r_state;
  arb_state_e         w_state_nx;
  logic [NUM_REQ-1:0] r_gnt;
  logic [NUM_REQ-1:0] w_gnt_nx;
  logic [NUM_REQ-1:0] w_acc;
  logic [NUM_REQ-1:0] w_pick_oh;
  logic [IW-1:0]      r_owner;
  logic [IW-1:0]      w_owner_nx;
  logic [IW-1:0]      r_ptr;
  logic [IW-1:0]      w_ptr_nx;
  logic [IW-1:0]      w_pick_idx;
  logic [CW-1:0]      r_cnt;
  logic [CW-1:0]      w_cnt_nx;
  logic               w_pick_vld;
  logic               w_wr_en;
  logic               w_own_req;
  logic               r_exp;
  logic               r_err_ovf;
  logic               r_err_ack;

  rr_picker #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_pick (
    .i_req (bus.req),
    .i_ptr (r_ptr),
    .o_oh  (w_pick_oh),
    .o_idx (w_pick_idx),
    .o_vld (w_pick_vld)
  );

  // r_gnt is zero outside GRANT, so no accept
  // can slip through while arbitrating
  assign w_acc =
    r_gnt & bus.req & {NUM_REQ{~bus.fifo_full}};
  assign w_wr_en   = |w_acc;
  assign w_own_req = bus.req[r_owner];

  assign bus.acc          = w_acc;
  assign bus.fifo_wr_en   = w_wr_en;
  assign bus.fifo_data_in =
    bus.req_data[r_owner*DATA_W +: DATA_W];
  assign bus.gnt          = r_gnt;
  assign bus.owner        = r_owner;
  assign bus.busy         = (r_state == GRANT);
  assign bus.err_overflow = r_err_ovf;
  assign bus.err_ack      = r_err_ack;

  always_comb begin
    w_state_nx = r_state;
    w_gnt_nx   = r_gnt;
    w_owner_nx = r_owner;
    w_ptr_nx   = r_ptr;
    w_cnt_nx   = r_cnt;
    unique case (r_state)
      IDLE: begin
        if (w_pick_vld) begin
          w_state_nx = GRANT;
          w_gnt_nx   = w_pick_oh;
          w_owner_nx = w_pick_idx;
          w_ptr_nx   = w_pick_idx;
          w_cnt_nx   = '0;
        end
      end
      GRANT: begin
        if (!w_own_req) begin
          w_state_nx = IDLE;
          w_gnt_nx   = '0;
          w_owner_nx = '0;
        end else if (w_wr_en) begin
          if (r_cnt == LAST) begin
            w_state_nx = IDLE;
            w_gnt_nx   = '0;
            w_owner_nx = '0;
            w_cnt_nx   = '0;
          end else begin
            w_cnt_nx = r_cnt + 1'b1;
          end
        end
      end
      default: begin
        w_state_nx = IDLE;
        w_gnt_nx   = '0;
        w_owner_nx = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_gnt   <= '0;
      r_owner <= '0;
      r_ptr   <= IW'(NUM_REQ - 1);
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nx;
      r_gnt   <= w_gnt_nx;
      r_owner <= w_owner_nx;
      r_ptr   <= w_ptr_nx;
      r_cnt   <= w_cnt_nx;
    end
  end

  // the FIFO acks one cycle after each write,
  // so compare against last cycle's wr_en
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_exp     <= 1'b0;
      r_err_ovf <= 1'b0;
      r_err_ack <= 1'b0;
    end else begin
      r_exp <= w_wr_en;
      if (bus.fifo_wr_ack != r_exp)
        r_err_ack <= 1'b1;
      if (bus.fifo_overflow)
        r_err_ovf <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter with a FIFO
// write-side model and a burst-level reference model.
module tb_fifo_wr_arbiter;

  localparam int N     = 4;
  localparam int DW    = 16;
  localparam int MB    = 4;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fifo_wr_arbiter_if #(.NUM_REQ(N), .DATA_W(DW)) bus ();

  fifo_wr_arbiter #(
    .NUM_REQ   (N),
    .DATA_W    (DW),
    .MAX_BURST (MB)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_tot = 0;
  int n_pass = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s act=%0h exp=%0h",
                  nm, act, exp);
  endtask

  // FIFO write side
  int   f_cnt;
  logic f_ack, f_ovf;
  logic rd = 1'b0;
  logic ack_kill = 1'b0;
  logic ovf_force = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f_cnt <= 0;
      f_ack <= 1'b0;
      f_ovf <= 1'b0;
    end else begin
      f_cnt <= f_cnt
        + ((bus.fifo_wr_en && f_cnt < DEPTH) ? 1 : 0)
        - ((rd && f_cnt > 0) ? 1 : 0);
      f_ack <= bus.fifo_wr_en && (f_cnt < DEPTH);
      f_ovf <= bus.fifo_wr_en && (f_cnt == DEPTH);
    end
  end

  assign bus.fifo_full     = (f_cnt == DEPTH);
  assign bus.fifo_wr_ack   = f_ack & ~ack_kill;
  assign bus.fifo_overflow = f_ovf | ovf_force;

  // producers: each holds a word until accepted
  int          left [N];
  int          sent [N];
  logic [DW-1:0] base [N];
  bit          auto_p = 1'b0;

  task automatic drive_prod();
    for (int i = 0; i < N; i++) begin
      bus.req[i] = (left[i] > 0);
      bus.req_data[i*DW +: DW] = base[i] + DW'(sent[i]);
    end
  endtask

  // reference model: owner -1 means no grant
  int m_own, m_beats, m_last;
  bit m_eack, m_eovf, m_pwr;
  logic [N-1:0]  e_gnt, e_acc, s_req, last_acc;
  logic          e_wr, s_ack, s_ovf;
  logic [DW-1:0] e_data;

  task automatic model_reset();
    m_own = -1;
    m_beats = 0;
    m_last = N - 1;
    m_eack = 0;
    m_eovf = 0;
    m_pwr = 0;
  endtask

  task automatic model_commit();
    int c;
    if (s_ack != m_pwr) m_eack = 1;
    if (s_ovf) m_eovf = 1;
    m_pwr = e_wr;
    if (m_own < 0) begin
      for (int k = 1; k <= N; k++) begin
        c = (m_last + k) % N;
        if (m_own < 0 && s_req[c]) begin
          m_own = c;
          m_last = c;
          m_beats = 0;
        end
      end
    end else if (!s_req[m_own]) begin
      m_own = -1;
    end else if (e_wr) begin
      m_beats++;
      if (m_beats == MB) m_own = -1;
    end
  endtask

  task automatic tick();
    int o;
    @(negedge clk);
    o = (m_own < 0) ? 0 : m_own;
    e_gnt = '0;
    e_acc = '0;
    if (m_own >= 0) begin
      e_gnt[m_own] = 1'b1;
      if (bus.req[m_own] && !bus.fifo_full)
        e_acc[m_own] = 1'b1;
    end
    e_wr = |e_acc;
    e_data = bus.req_data[o*DW +: DW];
    chk("gnt", 32'(bus.gnt), 32'(e_gnt));
    chk("acc", 32'(bus.acc), 32'(e_acc));
    chk("wr_en", 32'(bus.fifo_wr_en), 32'(e_wr));
    chk("data", 32'(bus.fifo_data_in), 32'(e_data));
    chk("owner", 32'(bus.owner), o);
    chk("busy", 32'(bus.busy), 32'(m_own >= 0));
    chk("err_ack", 32'(bus.err_ack), 32'(m_eack));
    chk("err_ovf", 32'(bus.err_overflow),
        32'(m_eovf));
    s_ack = bus.fifo_wr_ack;
    s_ovf = bus.fifo_overflow;
    s_req = bus.req;
    @(posedge clk);
    if (rst_n) model_commit();
    else model_reset();
    last_acc = e_acc;
    #1;
    if (auto_p) begin
      for (int i = 0; i < N; i++) begin
        if (last_acc[i]) begin
          sent[i]++;
          left[i]--;
        end
      end
      drive_prod();
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    rd = 1'b0;
    ack_kill = 1'b0;
    ovf_force = 1'b0;
    for (int i = 0; i < N; i++) begin
      left[i] = 0;
      sent[i] = 0;
      base[i] = '0;
    end
    drive_prod();
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  function automatic int oh2i(input logic [N-1:0] v);
    int r;
    r = -1;
    for (int i = 0; i < N; i++) if (v[i]) r = i;
    return r;
  endfunction

  typedef struct {
    logic [N-1:0]  req;
    logic [DW-1:0] d0;
    logic [N-1:0]  gnt;
    logic [N-1:0]  acc;
    logic          wr;
    logic [DW-1:0] din;
  } vec_t;

  vec_t tv [7];
  logic [N-1:0] hg [24];
  logic [N-1:0] ha [24];
  int seg_own [8];
  int seg_beat [8];
  int gaps [8];
  int nseg, ngap, zrun;
  bit reached;

  initial begin
    tv[0] = '{4'b0001, 16'hA000, 4'b0000, 4'b0000, 1'b0, 16'hA000};
    tv[1] = '{4'b0001, 16'hA000, 4'b0001, 4'b0001, 1'b1, 16'hA000};
    tv[2] = '{4'b0001, 16'hA001, 4'b0001, 4'b0001, 1'b1, 16'hA001};
    tv[3] = '{4'b0001, 16'hA002, 4'b0001, 4'b0001, 1'b1, 16'hA002};
    tv[4] = '{4'b0001, 16'hA003, 4'b0001, 4'b0001, 1'b1, 16'hA003};
    tv[5] = '{4'b0000, 16'hA003, 4'b0000, 4'b0000, 1'b0, 16'hA003};
    tv[6] = '{4'b0000, 16'hA003, 4'b0000, 4'b0000, 1'b0, 16'hA003};

    // reset state
    do_reset();
    #1;
    chk("rst_gnt", 32'(bus.gnt), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_wr", 32'(bus.fifo_wr_en), 0);
    chk("rst_owner", 32'(bus.owner), 0);

    // single producer burst, table driven
    auto_p = 1'b0;
    for (int i = 0; i < 7; i++) begin
      bus.req = tv[i].req;
      bus.req_data = '0;
      bus.req_data[DW-1:0] = tv[i].d0;
      #1;
      chk($sformatf("t1_gnt%0d", i),
          32'(bus.gnt), 32'(tv[i].gnt));
      chk($sformatf("t1_acc%0d", i),
          32'(bus.acc), 32'(tv[i].acc));
      chk($sformatf("t1_wr%0d", i),
          32'(bus.fifo_wr_en), 32'(tv[i].wr));
      chk($sformatf("t1_din%0d", i),
          32'(bus.fifo_data_in), 32'(tv[i].din));
      tick();
    end
    chk("t1_fifo_cnt", f_cnt, 4);
    chk("t1_err_ack", 32'(bus.err_ack), 0);
    chk("t1_err_ovf", 32'(bus.err_overflow), 0);

    // all four requesting, FIFO drained
    do_reset();
    auto_p = 1'b1;
    rd = 1'b1;
    for (int i = 0; i < N; i++) begin
      left[i] = 1000;
      base[i] = DW'(i << 12);
    end
    drive_prod();
    for (int k = 0; k < 24; k++) begin
      tick();
      #2;
      hg[k] = bus.gnt;
      ha[k] = bus.acc;
    end
    nseg = 0;
    ngap = 0;
    zrun = 0;
    for (int k = 0; k < 24; k++) begin
      if (hg[k] == '0) begin
        zrun++;
      end else begin
        if (k == 0 || hg[k] != hg[k-1]) begin
          if (nseg > 0 && ngap < 8) begin
            gaps[ngap] = zrun;
            ngap++;
          end
          if (nseg < 8) begin
            seg_own[nseg] = oh2i(hg[k]);
            seg_beat[nseg] = 0;
          end
          nseg++;
        end
        zrun = 0;
        if (ha[k] != '0 && nseg <= 8)
          seg_beat[nseg-1]++;
      end
    end
    chk("t2_nseg", nseg, 5);
    chk("t2_ngap", ngap, 4);
    for (int s = 0; s < 5 && s < nseg; s++) begin
      chk($sformatf("t2_own%0d", s),
          seg_own[s], s % N);
      chk($sformatf("t2_beats%0d", s),
          seg_beat[s], MB);
    end
    for (int g = 0; g < ngap; g++)
      chk($sformatf("t2_gap%0d", g), gaps[g], 1);

    // FIFO goes full in the middle of owner 2's burst
    do_reset();
    auto_p = 1'b1;
    left[0] = 6;
    base[0] = 16'hB000;
    base[2] = 16'hC200;
    drive_prod();
    for (int k = 0; k < 40 && !(f_cnt == 6 &&
         left[0] == 0 && !bus.busy); k++)
      tick();
    chk("t3_cnt6", f_cnt, 6);
    left[2] = 4;
    drive_prod();
    reached = 1'b0;
    for (int k = 0; k < 20 && !reached; k++) begin
      tick();
      #1;
      reached = (bus.gnt == 4'b0100) &&
                bus.fifo_full;
    end
    chk("t3_stall_seen", 32'(reached), 1);
    #1;
    chk("t3_acc_full", 32'(bus.acc), 0);
    chk("t3_wr_full", 32'(bus.fifo_wr_en), 0);
    tick();
    tick();
    #1;
    chk("t3_gnt_hold", 32'(bus.gnt), 32'h4);
    chk("t3_wr_hold", 32'(bus.fifo_wr_en), 0);
    rd = 1'b1;
    tick();
    rd = 1'b0;
    #1;
    chk("t3_acc_resume", 32'(bus.acc), 32'h4);
    chk("t3_data3", 32'(bus.fifo_data_in), 32'hC202);
    tick();
    #1;
    chk("t3_wr_full2", 32'(bus.fifo_wr_en), 0);
    chk("t3_gnt_hold2", 32'(bus.gnt), 32'h4);
    rd = 1'b1;
    tick();
    rd = 1'b0;
    #1;
    chk("t3_wr_last", 32'(bus.fifo_wr_en), 1);
    tick();
    #1;
    chk("t3_gnt_end", 32'(bus.gnt), 0);
    chk("t3_err_ovf", 32'(bus.err_overflow), 0);

    // owner 1 drops its request after two beats
    do_reset();
    auto_p = 1'b1;
    rd = 1'b1;
    left[1] = 2;
    left[3] = 4;
    drive_prod();
    tick();
    left[0] = 4;
    drive_prod();
    #1;
    chk("t4_gnt1", 32'(bus.gnt), 32'h2);
    tick();
    tick();
    #1;
    chk("t4_gnt_drop", 32'(bus.gnt), 32'h2);
    chk("t4_acc_drop", 32'(bus.acc), 0);
    tick();
    #1;
    chk("t4_idle", 32'(bus.gnt), 0);
    tick();
    #1;
    chk("t4_next3", 32'(bus.gnt), 32'h8);
    for (int b = 0; b < MB; b++) begin
      chk($sformatf("t4_beat%0d", b),
          32'(bus.acc), 32'h8);
      tick();
      #1;
    end
    chk("t4_end", 32'(bus.gnt), 0);

    // reset in the middle of owner 3's burst
    do_reset();
    auto_p = 1'b1;
    rd = 1'b1;
    left[3] = 8;
    drive_prod();
    tick();
    tick();
    tick();
    left[0] = 4;
    drive_prod();
    #1;
    chk("t5_pre_gnt", 32'(bus.gnt), 32'h8);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("t5_rst_gnt", 32'(bus.gnt), 0);
    chk("t5_rst_wr", 32'(bus.fifo_wr_en), 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    #1;
    chk("t5_first0", 32'(bus.gnt), 32'h1);

    // error flags
    do_reset();
    auto_p = 1'b1;
    rd = 1'b1;
    left[0] = 1;
    drive_prod();
    tick();
    tick();
    ack_kill = 1'b1;
    tick();
    ack_kill = 1'b0;
    #1;
    chk("t6_err_ack", 32'(bus.err_ack), 1);
    chk("t6_ovf_clr", 32'(bus.err_overflow), 0);
    ovf_force = 1'b1;
    tick();
    ovf_force = 1'b0;
    #1;
    chk("t6_err_ovf", 32'(bus.err_overflow), 1);
    repeat (3) tick();
    #1;
    chk("t6_ack_sticky", 32'(bus.err_ack), 1);
    chk("t6_ovf_sticky", 32'(bus.err_overflow), 1);
    do_reset();
    #1;
    chk("t6_ack_rst", 32'(bus.err_ack), 0);
    chk("t6_ovf_rst", 32'(bus.err_overflow), 0);

    // random traffic against the model
    auto_p = 1'b1;
    for (int k = 0; k < 600; k++) begin
      rd = ($urandom_range(0, 2) != 0);
      for (int i = 0; i < N; i++) begin
        if (left[i] == 0 &&
            $urandom_range(0, 3) == 0) begin
          left[i] = $urandom_range(1, 6);
          sent[i] = 0;
          base[i] = DW'($urandom);
        end
      end
      drive_prod();
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
